// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel-clock enable.
// Outputs are registered one enabled cycle behind the internal h/v counters.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CW         = 10,
    parameter int FCW        = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en,
    output logic           h_sync,
    output logic           v_sync,
    output logic [CW-1:0]  s_x,
    output logic [CW-1:0]  s_y,
    output logic           data_enable,
    output logic           line_start,
    output logic           frame_start,
    output logic           vblank_start,
    output logic [FCW-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic HS_ON = (H_SYNC_POL != 0);
    localparam logic VS_ON = (V_SYNC_POL != 0);

    if (((64'd1 << CW) < 64'(H_TOTAL)) || ((64'd1 << CW) < 64'(V_TOTAL))) begin : g_cw_check
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          de_next;
    logic          hs_act;
    logic          vs_act;
    logic          h_zero;
    logic          at_origin;
    logic          at_vblank;
    logic          seen_frame;

    always_comb begin
        h_last    = (h_cnt == CW'(H_TOTAL - 1));
        v_last    = (v_cnt == CW'(V_TOTAL - 1));
        de_next   = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
        hs_act    = (h_cnt >= CW'(H_ACTIVE + H_FP)) && (h_cnt < CW'(H_ACTIVE + H_FP + H_SYNC));
        vs_act    = (v_cnt >= CW'(V_ACTIVE + V_FP)) && (v_cnt < CW'(V_ACTIVE + V_FP + V_SYNC));
        h_zero    = (h_cnt == '0);
        at_origin = h_zero && (v_cnt == '0);
        at_vblank = h_zero && (v_cnt == CW'(V_ACTIVE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + CW'(1);
            end else begin
                h_cnt <= h_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_x         <= '0;
            s_y         <= '0;
            data_enable <= 1'b0;
            h_sync      <= ~HS_ON;
            v_sync      <= ~VS_ON;
        end else if (pix_en) begin
            s_x         <= h_cnt;
            s_y         <= v_cnt;
            data_enable <= de_next;
            h_sync      <= hs_act ? HS_ON : ~HS_ON;
            v_sync      <= vs_act ? VS_ON : ~VS_ON;
        end
    end

    // Strobes self-clear on every non-enabled edge; the first frame after reset is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
            seen_frame   <= 1'b0;
        end else if (pix_en) begin
            line_start   <= h_zero;
            frame_start  <= at_origin;
            vblank_start <= at_vblank;
            if (at_origin) begin
                seen_frame <= 1'b1;
                if (seen_frame) begin
                    frame_count <= frame_count + FCW'(1);
                end
            end
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator, the successor to the fixed 640x480 display timing block. Horizontal and vertical porch, sync and active counts, sync polarity and coordinate width are all set by parameters. A pixel-clock enable lets it run from a faster system clock. Outputs are registered and include line, frame and vblank strobes plus a frame counter, and it feeds the pixel pipeline and the VGA/DVI output stage.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, active level of h_sync (0 = active-low)
V_SYNC_POL, 0, active level of v_sync
CW, 10, coordinate width; must hold max(H_TOTAL-1, V_TOTAL-1)
FCW, 8, frame counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pix_en  in  1  pixel clock enable; timing advances only on clk edges with pix_en=1
h_sync  out  1  horizontal sync, polarity per H_SYNC_POL
v_sync  out  1  vertical sync, polarity per V_SYNC_POL
s_x  out  CW  current column, 0..H_TOTAL-1
s_y  out  CW  current line, 0..V_TOTAL-1
data_enable  out  1  high when s_x<H_ACTIVE and s_y<V_ACTIVE
line_start  out  1  one-clk strobe when s_x becomes 0
frame_start  out  1  one-clk strobe when (s_x,s_y) becomes (0,0)
vblank_start  out  1  one-clk strobe when (s_x,s_y) becomes (0,V_ACTIVE)
frame_count  out  FCW  count of completed frames, wraps modulo 2^FCW

Behaviour:
- Derived counts: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. The line period is exactly H_TOTAL enabled cycles and the frame period is exactly H_TOTAL*V_TOTAL enabled cycles (no extra count at wrap).
- Internal counters: h_cnt and v_cnt.
  - On clk with pix_en=1, h_cnt increments.
  - When h_cnt=H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 together with the h_cnt wrap.
- Output registers, latency 1 enabled cycle:
  - On each enabled edge, s_x/s_y load the current h_cnt/v_cnt.
  - On the same edge, h_sync, v_sync and data_enable load the decode of the current h_cnt/v_cnt. All outputs are therefore mutually aligned.
- Sync decode:
  - h_sync is at H_SYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else at ~H_SYNC_POL.
  - v_sync uses the same form on y with the V parameters.
- pix_en=0: counters and all level outputs hold their values.
- Strobes:
  - line_start, frame_start and vblank_start are high for exactly one clk, on the enabled edge that loads the qualifying coordinates.
  - They are cleared on the next clk edge whether or not pix_en is high.
- frame_count increments on the same edge that asserts frame_start, except the first frame_start after reset. It wraps to 0 after 2^FCW-1.
- Reset (asynchronous, takes effect without a clock edge):
  - h_cnt=0, v_cnt=0, s_x=0, s_y=0, data_enable=0.
  - h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL.
  - All strobes 0, frame_count=0.
- After reset release, the first enabled edge yields s_x=0, s_y=0, data_enable=1, line_start=1 and frame_start=1.
- Reset asserted mid-frame restarts the raster at (0,0). Any partial frame is not counted.
- Parameter legality: all timing parameters are >=1. An elaboration-time check fails if CW is too narrow.

Test Plan:
1. Defaults, pix_en=1 after reset release -> first edge gives s_x=0, s_y=0, data_enable=1, frame_start=1 for one clk. data_enable stays 1 through s_x=639 and is 0 at s_x=640. line_start recurs every 800 clk.
2. Defaults, observe one line -> h_sync=0 exactly while s_x=656..751 (96 clk) and 1 at s_x=752. s_x wraps from 799 to 0 with s_y incrementing.
3. Defaults, run 3 frames -> v_sync=0 only on lines 490..491. vblank_start fires at (0,480). frame_start period is 420000 clk. frame_count reads 1 then 2.
4. pix_en alternating 1/0 -> levels hold during pix_en=0 cycles. Each strobe is exactly 1 clk wide. frame period is 840000 clk.
5. Async reset pulsed between clk edges at s_x=300, s_y=200 -> outputs reach reset values before the next clk edge. After release, the raster restarts at (0,0) and frame_count=0.
6. H=4/1/2/1, V=3/1/1/1, both polarities 1, CW=4 -> line period 8, frame period 48. h_sync=1 only at s_x=5..6. v_sync=1 only on line 4. frame_count wraps at 256 frames with FCW=8.
